// File: rtl/uart_sram_cmd_pkg.sv
// rtl/uart_sram_cmd_pkg.sv - states and byte codes for the UART command front-end
// UART_SRAM_CMD_CHECKSUM_EN adds the CHK and NAK states.
package uart_sram_cmd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR2,
    S_ADDR1,
    S_ADDR0,
    S_DATA1,
    S_DATA0,
    S_ISSUE,
    S_WAIT,
    S_RESP_HI,
    S_RESP_LO,
    S_ACK
`ifdef UART_SRAM_CMD_CHECKSUM_EN
    , S_CHK
    , S_NAK
`endif
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

endpackage

// File: rtl/uart_sram_cmd_timer.sv
// rtl/uart_sram_cmd_timer.sv - loadable down-counter shared by byte timeout and access wait
module uart_sram_cmd_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_sram_cmd.sv
// rtl/uart_sram_cmd.sv - UART byte frames to SRAM write/read ticks with byte responses
// UART_SRAM_CMD_CHECKSUM_EN enables the trailing XOR checksum byte.
module uart_sram_cmd
  import uart_sram_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 16,
  parameter int ACCESS_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  write_tick,
  output logic                  read_tick,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] wdata_out,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  busy,
  output logic                  err_pulse
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + ACCESS_CYCLES + 1);

`ifdef UART_SRAM_CMD_CHECKSUM_EN
  localparam state_t S_FRAME_END = S_CHK;
`else
  localparam state_t S_FRAME_END = S_ISSUE;
`endif

  state_t                state, state_n;
  logic                  is_wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q, rdata_q;
  logic                  err_q, err_n;
  logic                  t_load, t_expired;
  logic [TW-1:0]         t_val;
  logic [15:0]           resp_word;
  logic                  cmd_ok, byte_state, addr_state, data_state;
`ifdef UART_SRAM_CMD_CHECKSUM_EN
  logic [7:0]            chk_q;
`endif

  assign cmd_ok     = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign addr_state = (state == S_ADDR2) || (state == S_ADDR1) || (state == S_ADDR0);
  assign data_state = (state == S_DATA1) || (state == S_DATA0);
`ifdef UART_SRAM_CMD_CHECKSUM_EN
  assign byte_state = addr_state || data_state || (state == S_CHK);
`else
  assign byte_state = addr_state || data_state;
`endif

  uart_sram_cmd_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (1'b1),
    .expired  (t_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    t_load  = 1'b0;
    t_val   = TW'(TIMEOUT_CYCLES - 1);
    if (byte_state) begin
      // every received byte restarts the inter-byte timeout
      if (rx_valid) begin
        t_load = 1'b1;
        case (state)
          S_ADDR2: state_n = S_ADDR1;
          S_ADDR1: state_n = S_ADDR0;
          S_ADDR0: state_n = is_wr ? S_DATA1 : S_FRAME_END;
          S_DATA1: state_n = S_DATA0;
          S_DATA0: state_n = S_FRAME_END;
`ifdef UART_SRAM_CMD_CHECKSUM_EN
          S_CHK: begin
            if (rx_data == chk_q) begin
              state_n = S_ISSUE;
            end else begin
              state_n = S_NAK;
              err_n   = 1'b1;
            end
          end
`endif
          default: state_n = state;
        endcase
      end else if (t_expired) begin
        state_n = S_IDLE;
        err_n   = 1'b1;
      end
    end else if (state == S_IDLE) begin
      if (rx_valid) begin
        if (cmd_ok) begin
          state_n = S_ADDR2;
          t_load  = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
    end else begin
      // bytes arriving while an access is in flight are dropped
      err_n = rx_valid;
      case (state)
        S_ISSUE: begin
          state_n = S_WAIT;
          t_load  = 1'b1;
          t_val   = TW'(ACCESS_CYCLES - 2);
        end
        S_WAIT:    if (t_expired) state_n = is_wr ? S_ACK : S_RESP_HI;
        S_RESP_HI: if (tx_ready) state_n = S_RESP_LO;
        S_RESP_LO: if (tx_ready) state_n = S_IDLE;
        S_ACK:     if (tx_ready) state_n = S_IDLE;
`ifdef UART_SRAM_CMD_CHECKSUM_EN
        S_NAK:     if (tx_ready) state_n = S_IDLE;
`endif
        default:   state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_wr   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
`ifdef UART_SRAM_CMD_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      if (state == S_IDLE && rx_valid && cmd_ok) begin
        is_wr <= (rx_data == CMD_WR);
`ifdef UART_SRAM_CMD_CHECKSUM_EN
        chk_q <= rx_data;
`endif
      end
      // shifting truncates from the top, leaving the low bits of the big-endian field
      if (rx_valid && addr_state) addr_q <= ADDR_WIDTH'({addr_q, rx_data});
      if (rx_valid && data_state) data_q <= DATA_WIDTH'({data_q, rx_data});
`ifdef UART_SRAM_CMD_CHECKSUM_EN
      if (rx_valid && (addr_state || data_state)) chk_q <= chk_q ^ rx_data;
`endif
      if (state == S_WAIT && t_expired && !is_wr) rdata_q <= sram_rdata;
    end
  end

  assign resp_word = 16'(rdata_q);

  always_comb begin
    write_tick = 1'b0;
    read_tick  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      S_ISSUE: begin
        write_tick = is_wr;
        read_tick  = !is_wr;
      end
      S_RESP_HI: begin
        tx_valid = 1'b1;
        tx_data  = resp_word[15:8];
      end
      S_RESP_LO: begin
        tx_valid = 1'b1;
        tx_data  = resp_word[7:0];
      end
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = RSP_ACK;
      end
`ifdef UART_SRAM_CMD_CHECKSUM_EN
      S_NAK: begin
        tx_valid = 1'b1;
        tx_data  = RSP_ERR;
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign err_pulse = err_q;
  assign addr_out  = addr_q;
  assign wdata_out = data_q;

endmodule

// File: tb/tb_uart_sram_cmd.sv
// tb/tb_uart_sram_cmd.sv - directed and randomized frames against a queue-based reference model
module tb_uart_sram_cmd;

  localparam int AW  = 19;
  localparam int DW  = 16;
  localparam int ACC = 4;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          write_tick, read_tick;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] wdata_out;
  logic [DW-1:0] sram_rdata = '0;
  logic          busy, err_pulse;

  always #5 clk = ~clk;

  uart_sram_cmd #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(ACC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .write_tick(write_tick), .read_tick(read_tick), .addr_out(addr_out),
    .wdata_out(wdata_out), .sram_rdata(sram_rdata), .busy(busy), .err_pulse(err_pulse)
  );

  int passed = 0;
  int total  = 0;

  // observations, written only by the monitor
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0, unstable_cnt = 0;
  logic [7:0]  tx_log[$];
  logic [23:0] addr_log[$];
  logic [15:0] wd_log[$];
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0]  prev_d = 8'h00;

  always @(negedge clk) begin
    if (write_tick === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      addr_log.push_back(24'(addr_out));
      wd_log.push_back(16'(wdata_out));
    end
    if (read_tick === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      addr_log.push_back(24'(addr_out));
    end
    if (write_tick === 1'b1 && read_tick === 1'b1) both_cnt <= both_cnt + 1;
    if (err_pulse === 1'b1) err_cnt <= err_cnt + 1;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_log.push_back(tx_data);
    if (prev_v === 1'b1 && prev_r === 1'b0 && rst_n === 1'b1 &&
        (tx_valid !== 1'b1 || tx_data !== prev_d)) unstable_cnt <= unstable_cnt + 1;
    prev_v <= tx_valid;
    prev_r <= tx_ready;
    prev_d <= tx_data;
  end

  // reference model expectations
  int          e_wr = 0, e_rd = 0, e_err = 0;
  logic [7:0]  e_tx[$];
  logic [23:0] e_addr[$];
  logic [15:0] e_wd[$];
  int          tx_idx = 0, ad_idx = 0, wd_idx = 0;
  logic [23:0] amask = (24'h1 << AW) - 24'h1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_raw(input logic [7:0] f[$]);
    foreach (f[i]) send(f[i]);
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
`ifdef UART_SRAM_CMD_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (f[i]) x ^= f[i];
    f.push_back(x);
`endif
    send_raw(f);
  endtask

  task automatic wait_idle(input string tag, input int bound, input bit stall);
    int n = 0;
    while (busy === 1'b1 && n < bound) begin
      tx_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      step(1);
      n++;
    end
    tx_ready = 1'b1;
    step(2);
    chk({tag, "/idle"}, busy, 0);
  endtask

  task automatic verify(input string tag);
    chk({tag, "/wr_ticks"}, wr_cnt, e_wr);
    chk({tag, "/rd_ticks"}, rd_cnt, e_rd);
    chk({tag, "/errs"}, err_cnt, e_err);
    chk({tag, "/both_ticks"}, both_cnt, 0);
    chk({tag, "/tx_unstable"}, unstable_cnt, 0);
    chk({tag, "/tx_count"}, tx_log.size(), e_tx.size());
    while (tx_idx < e_tx.size()) begin
      chk({tag, "/tx_byte"}, (tx_idx < tx_log.size()) ? 32'(tx_log[tx_idx]) : 32'hDEAD, e_tx[tx_idx]);
      tx_idx++;
    end
    while (ad_idx < e_addr.size()) begin
      chk({tag, "/addr"}, (ad_idx < addr_log.size()) ? 32'(addr_log[ad_idx]) : 32'hDEAD, e_addr[ad_idx]);
      ad_idx++;
    end
    while (wd_idx < e_wd.size()) begin
      chk({tag, "/wdata"}, (wd_idx < wd_log.size()) ? 32'(wd_log[wd_idx]) : 32'hDEAD, e_wd[wd_idx]);
      wd_idx++;
    end
  endtask

  task automatic run_frame(input string tag, input bit wr, input logic [23:0] a,
                           input logic [15:0] d, input logic [15:0] rd, input bit stall);
    logic [7:0] f[$];
    tx_ready   = 1'b1;
    sram_rdata = rd;
    if (wr) f = {8'h57, a[23:16], a[15:8], a[7:0], d[15:8], d[7:0]};
    else    f = {8'h52, a[23:16], a[15:8], a[7:0]};
    send_frame(f);
    chk({tag, "/tick"}, wr ? write_tick : read_tick, 1);
    e_addr.push_back(a & amask);
    if (wr) begin
      e_wr++;
      e_wd.push_back(d);
      e_tx.push_back(8'h4B);
    end else begin
      e_rd++;
      e_tx.push_back(rd[15:8]);
      e_tx.push_back(rd[7:0]);
    end
    wait_idle(tag, 300, stall);
    verify(tag);
  endtask

  initial begin
    logic [7:0] f[$];
    int n;

    step(3);
    chk("rst/busy", busy, 0);
    chk("rst/tx_valid", tx_valid, 0);
    chk("rst/ticks", {write_tick, read_tick}, 0);
    chk("rst/err", err_pulse, 0);
    chk("rst/addr", addr_out, 0);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    step(1);

    // directed write with access-window timing
    send_frame({8'h57, 8'h00, 8'h0F, 8'hAC, 8'h00, 8'h78});
    chk("wr/tick", write_tick, 1);
    chk("wr/rd_tick", read_tick, 0);
    chk("wr/addr_out", addr_out, 32'h00FAC);
    chk("wr/wdata_out", wdata_out, 32'h0078);
    step(ACC - 1);
    chk("wr/early_tx", tx_valid, 0);
    chk("wr/addr_hold", addr_out, 32'h00FAC);
    step(1);
    chk("wr/tx_valid", tx_valid, 1);
    chk("wr/tx_data", tx_data, 32'h4B);
    e_wr++; e_addr.push_back(24'h000FAC); e_wd.push_back(16'h0078); e_tx.push_back(8'h4B);
    wait_idle("wr", 50, 1'b0);
    verify("wr");

    // directed read with a 5-cycle stall before each response byte
    tx_ready   = 1'b0;
    sram_rdata = 16'hDEAD;
    send_frame({8'h52, 8'h00, 8'h0F, 8'hAC});
    chk("rd/tick", read_tick, 1);
    sram_rdata = 16'h1234;
    step(ACC);
    sram_rdata = 16'hBEEF;
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin step(1); n++; end
    chk("rd/tx_valid_hi", tx_valid, 1);
    step(5);
    chk("rd/hold_hi", tx_data, 32'h12);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    chk("rd/b2b_valid", tx_valid, 1);
    chk("rd/tx_lo", tx_data, 32'h34);
    step(5);
    chk("rd/hold_lo", tx_data, 32'h34);
    tx_ready = 1'b1;
    step(1);
    e_rd++; e_addr.push_back(24'h000FAC); e_tx.push_back(8'h12); e_tx.push_back(8'h34);
    wait_idle("rd", 50, 1'b0);
    verify("rd");

    // unknown command byte, then a normal read
    send(8'h41);
    e_err++;
    step(2);
    chk("unk/busy", busy, 0);
    verify("unk");
    run_frame("unk_next", 1'b0, 24'($urandom), 16'h0, 16'($urandom), 1'b0);

    // inter-byte timeout
    send_raw({8'h57, 8'h00, 8'h0F});
    chk("tmo/busy_mid", busy, 1);
    step(TMO - 10);
    chk("tmo/busy_before", busy, 1);
    step(20);
    chk("tmo/busy_after", busy, 0);
    e_err++;
    verify("tmo");
    run_frame("tmo_next", 1'b1, 24'($urandom), 16'($urandom), 16'h0, 1'b0);

    // overrun during WAIT must not start a new command
    sram_rdata = 16'hA55A;
    send_frame({8'h52, 8'h01, 8'h23, 8'h45});
    chk("ovr/tick", read_tick, 1);
    send(8'h52);
    e_err++; e_rd++;
    e_addr.push_back(24'h012345 & amask);
    e_tx.push_back(8'hA5); e_tx.push_back(8'h5A);
    wait_idle("ovr", 50, 1'b0);
    step(3);
    chk("ovr/still_idle", busy, 0);
    verify("ovr");

    // reset mid-frame; the leftover bytes are unknown commands
    send_raw({8'h57, 8'h00});
    rst_n = 1'b0;
    step(1);
    chk("mrst/busy", busy, 0);
    chk("mrst/tx", {tx_valid, tx_data}, 0);
    chk("mrst/ticks", {write_tick, read_tick}, 0);
    chk("mrst/addr", addr_out, 0);
    chk("mrst/wdata", wdata_out, 0);
    chk("mrst/err", err_pulse, 0);
    rst_n = 1'b1;
    send_raw({8'h0F, 8'hAC, 8'h00, 8'h78});
    e_err += 4;
    step(2);
    chk("mrst/busy_after", busy, 0);
    verify("mrst");

`ifdef UART_SRAM_CMD_CHECKSUM_EN
    // wrong checksum byte
    f = {8'h57, 8'h00, 8'h0F, 8'hAC, 8'h00, 8'h78};
    f.push_back(8'h57 ^ 8'h0F ^ 8'hAC ^ 8'h78 ^ 8'h01);
    send_raw(f);
    chk("badchk/tick", {write_tick, read_tick}, 0);
    e_err++;
    e_tx.push_back(8'h45);
    wait_idle("badchk", 50, 1'b0);
    verify("badchk");
`endif

    // randomized frames with random transmitter back-pressure
    for (int i = 0; i < 10; i++) begin
      run_frame("rand", 1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
